// File: rtl/i2c_pkg.sv
// Shared types and default sizing for the I2C SCL generator slice.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOW     = 2'd1,
        RELEASE = 2'd2,
        HIGH    = 2'd3
    } scl_state_t;

    localparam int unsigned I2C_CNT_W       = 16;
    localparam int unsigned I2C_MIN_DIV     = 4;
    localparam int unsigned I2C_SYNC_STAGES = 2;
    localparam int unsigned I2C_TO_W        = 20;

endpackage

// File: rtl/i2c_scl_gen_if.sv
// Control, bus and phase-strobe bundle between register block, SCL generator and byte engine.
interface i2c_scl_gen_if
    import i2c_pkg::*;
#(
    parameter int unsigned CNT_W = I2C_CNT_W,
    parameter int unsigned TO_W  = I2C_TO_W
);
    logic             en;
    logic [CNT_W-1:0] half_period;
    logic [TO_W-1:0]  timeout_limit;
    logic             err_clr;
    logic             scl_in;
    logic             scl_oe;
    logic             i2c_clk;
    logic             scl_fall_stb;
    logic             drive_stb;
    logic             scl_rise_stb;
    logic             sample_stb;
    logic             stretching;
    logic             timeout_err;
    logic             busy;

    modport master (
        input  en, half_period, timeout_limit, err_clr, scl_in,
        output scl_oe, i2c_clk, scl_fall_stb, drive_stb, scl_rise_stb,
               sample_stb, stretching, timeout_err, busy
    );

    modport slave (
        output en, half_period, timeout_limit, err_clr,
        input  scl_oe, i2c_clk, scl_fall_stb, drive_stb, scl_rise_stb,
               sample_stb, stretching, timeout_err, busy
    );
endinterface

// File: rtl/i2c_sync.sv
// Multi-flop single-bit synchroniser with a programmable reset level.
module i2c_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) ff <= {STAGES{rst_val}};
        else       ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/i2c_scl_gen.sv
// Controller-side SCL generator: programmable half period, stretch detection with timeout, phase strobes.
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CNT_W       = I2C_CNT_W,
    parameter int unsigned MIN_DIV     = I2C_MIN_DIV,
    parameter int unsigned SYNC_STAGES = I2C_SYNC_STAGES,
    parameter int unsigned TO_W        = I2C_TO_W
) (
    input  logic         ref_clk,
    input  logic         reset,
    i2c_scl_gen_if.master bus
);
    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_LOW     = LOW;
    localparam logic [1:0] S_RELEASE = RELEASE;
    localparam logic [1:0] S_HIGH    = HIGH;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hp_q, hp_d, hp_req;
    logic [TO_W-1:0]  to_q, to_d, to_inc;
    logic             err_q, err_d;
    logic             scl_s;
    logic             oe_q, clk_q, fall_q, drive_q, rise_q, sample_q, stretch_q, busy_q;

    i2c_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk     (ref_clk),
        .reset   (reset),
        .rst_val (1'b1),
        .d       (bus.scl_in),
        .q       (scl_s)
    );

    assign hp_req = (bus.half_period < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : bus.half_period;
    assign to_inc = (&to_q) ? to_q : to_q + TO_W'(1);

    // Next-state logic; hp is re-latched at every LOW/HIGH entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hp_d    = hp_q;
        to_d    = to_q;
        err_d   = err_q & ~bus.err_clr;
        case (state_q)
            S_IDLE: begin
                if (bus.en && !err_q) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    hp_d    = hp_req;
                end
            end
            S_LOW: begin
                if (cnt_q == hp_q - CNT_W'(1)) begin
                    state_d = S_RELEASE;
                    to_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                to_d = to_inc;
                // Timeout has priority over a rise seen in the same cycle
                if ((bus.timeout_limit != '0) && (to_inc >= bus.timeout_limit)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (scl_s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    hp_d    = hp_req;
                end
            end
            S_HIGH: begin
                if (cnt_q == hp_q - CNT_W'(1)) begin
                    cnt_d = '0;
                    if (bus.en) begin
                        state_d = S_LOW;
                        hp_d    = hp_req;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs registered from next-state so they align with the state they describe
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hp_q      <= '0;
            to_q      <= '0;
            err_q     <= 1'b0;
            oe_q      <= 1'b0;
            clk_q     <= 1'b1;
            fall_q    <= 1'b0;
            drive_q   <= 1'b0;
            rise_q    <= 1'b0;
            sample_q  <= 1'b0;
            stretch_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hp_q      <= hp_d;
            to_q      <= to_d;
            err_q     <= err_d;
            oe_q      <= (state_d == S_LOW);
            clk_q     <= (state_d == S_IDLE) || (state_d == S_HIGH);
            fall_q    <= (state_d == S_LOW)  && (state_q != S_LOW);
            drive_q   <= (state_d == S_LOW)  && (cnt_d == (hp_d >> 1));
            rise_q    <= (state_d == S_HIGH) && (state_q != S_HIGH);
            sample_q  <= (state_d == S_HIGH) && (cnt_d == (hp_d >> 1));
            stretch_q <= (state_d == S_RELEASE);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign bus.scl_oe       = oe_q;
    assign bus.i2c_clk      = clk_q;
    assign bus.scl_fall_stb = fall_q;
    assign bus.drive_stb    = drive_q;
    assign bus.scl_rise_stb = rise_q;
    assign bus.sample_stb   = sample_q;
    assign bus.stretching   = stretch_q;
    assign bus.timeout_err  = err_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed bench for i2c_scl_gen: period shape, clamping, stretch, timeout, stop and reset.
module tb_i2c_scl_gen;
    logic ref_clk = 1'b0;
    logic reset   = 1'b1;
    logic hold    = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    i2c_scl_gen_if bus ();

    assign bus.scl_in = ~bus.scl_oe & ~hold;

    i2c_scl_gen dut (
        .ref_clk (ref_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 ref_clk = ~ref_clk;

    // Walks one SCL period from its scl_fall_stb, measuring phase lengths and strobe positions
    task automatic walk(input int drop_at, input int hold_rel,
                        output int low_len, output int drive_idx, output int rel_len,
                        output int high_len, output int rise_idx, output int sample_idx,
                        output int n_stb, output bit ok);
        int g;
        g = 0; ok = 1'b1; low_len = 0; rel_len = 0; high_len = 0;
        drive_idx = -1; rise_idx = -1; sample_idx = -1; n_stb = 0;
        while (bus.scl_fall_stb !== 1'b1 && g < 300) begin @(negedge ref_clk); g++; end
        if (g >= 300) begin ok = 1'b0; return; end
        if (hold_rel >= 0) hold = 1'b1;
        while (bus.scl_oe === 1'b1 && low_len < 300) begin
            if (low_len == drop_at) bus.en = 1'b0;
            if (bus.drive_stb === 1'b1) drive_idx = low_len;
            n_stb += int'(bus.scl_fall_stb) + int'(bus.drive_stb) + int'(bus.scl_rise_stb) + int'(bus.sample_stb);
            low_len++; @(negedge ref_clk);
        end
        while (bus.stretching === 1'b1 && rel_len < 300) begin
            if (rel_len == hold_rel) hold = 1'b0;
            n_stb += int'(bus.scl_fall_stb) + int'(bus.drive_stb) + int'(bus.scl_rise_stb) + int'(bus.sample_stb);
            rel_len++; @(negedge ref_clk);
        end
        while (bus.busy === 1'b1 && bus.i2c_clk === 1'b1 && high_len < 300) begin
            if (bus.scl_rise_stb === 1'b1) rise_idx = high_len;
            if (bus.sample_stb === 1'b1) sample_idx = high_len;
            n_stb += int'(bus.scl_fall_stb) + int'(bus.drive_stb) + int'(bus.scl_rise_stb) + int'(bus.sample_stb);
            high_len++; @(negedge ref_clk);
        end
        if (low_len >= 300 || rel_len >= 300 || high_len >= 300) ok = 1'b0;
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.half_period = 16'd10; bus.timeout_limit = '0; bus.err_clr = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge ref_clk);
        vectors++; if (bus.scl_oe !== 1'b0) begin miscompares++; $display("FAIL reset_scl_oe got=%b exp=0", bus.scl_oe); end
        vectors++; if (bus.i2c_clk !== 1'b1) begin miscompares++; $display("FAIL reset_i2c_clk got=%b exp=1", bus.i2c_clk); end
        vectors++; if ({bus.scl_fall_stb, bus.drive_stb, bus.scl_rise_stb, bus.sample_stb} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_strobes got=%b exp=0000", {bus.scl_fall_stb, bus.drive_stb, bus.scl_rise_stb, bus.sample_stb}); end
        vectors++; if ({bus.stretching, bus.timeout_err, bus.busy} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags got=%b exp=000", {bus.stretching, bus.timeout_err, bus.busy}); end
        reset = 1'b0;
        repeat (3) @(negedge ref_clk);
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_no_en busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_steady();
        int ll, di, rl, hl, ri, si, ns; bit ok;
        bus.en = 1'b1;
        walk(-1, -1, ll, di, rl, hl, ri, si, ns, ok);
        walk(-1, -1, ll, di, rl, hl, ri, si, ns, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL steady_walk timed out"); end
        vectors++; if (ll !== 10) begin miscompares++; $display("FAIL steady_low got=%0d exp=10", ll); end
        vectors++; if (rl !== 3) begin miscompares++; $display("FAIL steady_release got=%0d exp=3", rl); end
        vectors++; if (hl !== 10) begin miscompares++; $display("FAIL steady_high got=%0d exp=10", hl); end
        vectors++; if (ll + rl + hl !== 23) begin miscompares++; $display("FAIL steady_period got=%0d exp=23", ll + rl + hl); end
        vectors++; if (di !== 5) begin miscompares++; $display("FAIL steady_drive_idx got=%0d exp=5", di); end
        vectors++; if (si !== 5) begin miscompares++; $display("FAIL steady_sample_idx got=%0d exp=5", si); end
        vectors++; if (ri !== 0) begin miscompares++; $display("FAIL steady_rise_idx got=%0d exp=0", ri); end
        vectors++; if (ns !== 4) begin miscompares++; $display("FAIL steady_strobe_count got=%0d exp=4", ns); end
    endtask

    task automatic test_clamp();
        int ll, di, rl, hl, ri, si, ns; bit ok;
        bus.half_period = 16'd1;
        walk(-1, -1, ll, di, rl, hl, ri, si, ns, ok);
        walk(-1, -1, ll, di, rl, hl, ri, si, ns, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL clamp_walk timed out"); end
        vectors++; if (ll !== 4) begin miscompares++; $display("FAIL clamp_low got=%0d exp=4", ll); end
        vectors++; if (hl !== 4) begin miscompares++; $display("FAIL clamp_high got=%0d exp=4", hl); end
        vectors++; if (ll + rl + hl !== 11) begin miscompares++; $display("FAIL clamp_period got=%0d exp=11", ll + rl + hl); end
        vectors++; if (di !== 2) begin miscompares++; $display("FAIL clamp_drive_idx got=%0d exp=2", di); end
        vectors++; if (si !== 2) begin miscompares++; $display("FAIL clamp_sample_idx got=%0d exp=2", si); end
        bus.half_period = 16'd10;
        walk(-1, -1, ll, di, rl, hl, ri, si, ns, ok);
    endtask

    task automatic test_stretch();
        int ll, di, rl, hl, ri, si, ns; bit ok;
        walk(-1, 40, ll, di, rl, hl, ri, si, ns, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL stretch_walk timed out"); end
        vectors++; if (rl !== 43) begin miscompares++; $display("FAIL stretch_release got=%0d exp=43", rl); end
        vectors++; if (ri !== 0) begin miscompares++; $display("FAIL stretch_rise_idx got=%0d exp=0", ri); end
        vectors++; if (hl !== 10) begin miscompares++; $display("FAIL stretch_high got=%0d exp=10", hl); end
        vectors++; if (bus.timeout_err !== 1'b0) begin miscompares++; $display("FAIL stretch_no_timeout got=%b exp=0", bus.timeout_err); end
    endtask

    task automatic test_timeout();
        int ll, di, rl, hl, ri, si, ns, busy_cnt; bit ok;
        bus.timeout_limit = 20'd20;
        walk(-1, 1000, ll, di, rl, hl, ri, si, ns, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL timeout_walk timed out"); end
        vectors++; if (rl !== 20) begin miscompares++; $display("FAIL timeout_release got=%0d exp=20", rl); end
        vectors++; if ({bus.timeout_err, bus.busy, bus.scl_oe, bus.i2c_clk} !== 4'b1001) begin
            miscompares++; $display("FAIL timeout_state err/busy/oe/clk got=%b exp=1001", {bus.timeout_err, bus.busy, bus.scl_oe, bus.i2c_clk}); end
        busy_cnt = 0;
        repeat (20) begin @(negedge ref_clk); busy_cnt += int'(bus.busy); end
        vectors++; if (busy_cnt !== 0) begin miscompares++; $display("FAIL timeout_blocks_restart busy_cycles got=%0d exp=0", busy_cnt); end
        hold = 1'b0;
        bus.err_clr = 1'b1;
        @(negedge ref_clk);
        bus.err_clr = 1'b0;
        vectors++; if ({bus.timeout_err, bus.busy} !== 2'b00) begin
            miscompares++; $display("FAIL err_clr err/busy got=%b exp=00", {bus.timeout_err, bus.busy}); end
        @(negedge ref_clk);
        vectors++; if (bus.scl_fall_stb !== 1'b1) begin miscompares++; $display("FAIL restart_after_clr fall got=%b exp=1", bus.scl_fall_stb); end
        bus.timeout_limit = '0;
    endtask

    task automatic test_en_drop();
        int ll, di, rl, hl, ri, si, ns, falls; bit ok;
        walk(3, -1, ll, di, rl, hl, ri, si, ns, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL endrop_walk timed out"); end
        vectors++; if ({ll, rl, hl} !== {32'd10, 32'd3, 32'd10}) begin
            miscompares++; $display("FAIL endrop_phases got=%0d/%0d/%0d exp=10/3/10", ll, rl, hl); end
        vectors++; if ({bus.busy, bus.i2c_clk, bus.scl_oe} !== 3'b010) begin
            miscompares++; $display("FAIL endrop_stop busy/clk/oe got=%b exp=010", {bus.busy, bus.i2c_clk, bus.scl_oe}); end
        falls = 0;
        repeat (30) begin @(negedge ref_clk); falls += int'(bus.scl_fall_stb); end
        vectors++; if (falls !== 0) begin miscompares++; $display("FAIL endrop_no_fall got=%0d exp=0", falls); end
    endtask

    task automatic test_reset_mid();
        int g;
        bus.en = 1'b1;
        g = 0;
        while (bus.scl_rise_stb !== 1'b1 && g < 300) begin @(negedge ref_clk); g++; end
        vectors++; if (g >= 300) begin miscompares++; $display("FAIL rstmid_wait_rise timed out"); end
        repeat (6) @(negedge ref_clk);
        reset = 1'b1;
        @(negedge ref_clk);
        vectors++; if ({bus.scl_oe, bus.i2c_clk, bus.busy, bus.stretching, bus.timeout_err} !== 5'b01000) begin
            miscompares++; $display("FAIL rstmid_values oe/clk/busy/str/err got=%b exp=01000", {bus.scl_oe, bus.i2c_clk, bus.busy, bus.stretching, bus.timeout_err}); end
        vectors++; if ({bus.scl_fall_stb, bus.drive_stb, bus.scl_rise_stb, bus.sample_stb} !== 4'b0000) begin
            miscompares++; $display("FAIL rstmid_strobes got=%b exp=0000", {bus.scl_fall_stb, bus.drive_stb, bus.scl_rise_stb, bus.sample_stb}); end
        reset = 1'b0;
        @(negedge ref_clk);
        vectors++; if ({bus.scl_fall_stb, bus.scl_oe, bus.busy} !== 3'b111) begin
            miscompares++; $display("FAIL rstmid_first_fall fall/oe/busy got=%b exp=111", {bus.scl_fall_stb, bus.scl_oe, bus.busy}); end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_clamp();
        test_stretch();
        test_timeout();
        test_en_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/i2c_scl_gen.md
Name: i2c_scl_gen

Overview:
Parametrised successor to the fixed-ratio I2C clock divider. Generates the controller-side SCL from ref_clk with:
- a runtime-programmable half period, clamped to a minimum;
- an open-drain output enable and a clean start/stop from bus-idle-high;
- target clock-stretch detection with an optional timeout;
- one-cycle phase strobes (fall, drive point, rise, sample point) for the I2C byte/bit engine.

Sits between the register block and the I2C controller FSM.

Parameters:
CNT_W, 16, width of the half-period counter and of the half_period input
MIN_DIV, 4, minimum effective half period in ref_clk cycles; smaller requests are clamped up to it
SYNC_STAGES, 2, flops in the scl_in synchroniser (at least 2)
TO_W, 20, width of the stretch-timeout counter and of timeout_limit

Ports:
ref_clk  in  1  sole clock
reset  in  1  synchronous, active-high reset
en  in  1  run request; deassertion finishes the current cycle and stops with SCL high
half_period  in  CNT_W  requested half period in ref_clk cycles
timeout_limit  in  TO_W  maximum stretch cycles; 0 disables the timeout
err_clr  in  1  clears timeout_err
scl_in  in  1  raw SCL bus level, asynchronous
scl_oe  out  1  1 = pull SCL low (open drain)
i2c_clk  out  1  internal SCL level model
scl_fall_stb  out  1  pulses in the first LOW cycle
drive_stb  out  1  pulses mid-LOW; the SDA change point
scl_rise_stb  out  1  pulses in the first HIGH cycle
sample_stb  out  1  pulses mid-HIGH; the SDA sample point
stretching  out  1  high while in RELEASE
timeout_err  out  1  sticky stretch-timeout flag
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values (synchronous, one edge): state=IDLE, scl_oe=0, i2c_clk=1, all strobes=0, stretching=0, timeout_err=0, busy=0, counters=0, synchroniser flops=1.
- Reset asserted mid-operation overrides everything: the bus is released at the next edge.
- Effective half period hp = max(half_period, MIN_DIV).
  - hp is latched when entering LOW or HIGH.
  - A change to half_period during a phase takes effect at the next phase.
- scl_in passes through an SYNC_STAGES-flop synchroniser to give scl_s. Only scl_s is used.
- FSM states: IDLE, LOW, RELEASE, HIGH.
- IDLE:
  - scl_oe=0, i2c_clk=1.
  - When en=1: go to LOW, set scl_oe=1, i2c_clk=0, count=0, and pulse scl_fall_stb in the first LOW cycle.
- LOW:
  - count runs 0..hp-1.
  - drive_stb is high in the cycle where count==hp/2 (floor).
  - At count==hp-1: go to RELEASE, set scl_oe=0, clear the timeout counter. This happens regardless of en.
- RELEASE:
  - stretching=1; i2c_clk stays 0.
  - When scl_s==1: go to HIGH, set i2c_clk=1, count=0, and pulse scl_rise_stb in the first HIGH cycle.
  - With an ideal pull-up (scl_in = ~scl_oe), RELEASE lasts exactly SYNC_STAGES+1 cycles. Anything longer is a target stretch.
  - The timeout counter increments every RELEASE cycle and saturates at all-ones.
  - If timeout_limit != 0 and the counter reaches timeout_limit: set timeout_err, go to IDLE, keep scl_oe=0.
  - If the timeout and the rise condition occur in the same cycle, the timeout wins.
- HIGH:
  - count runs 0..hp-1.
  - sample_stb is high in the cycle where count==hp/2.
  - scl_s going low during HIGH is ignored; arbitration is out of scope.
  - At count==hp-1: if en=1, go to LOW (same actions as entry from IDLE). Otherwise go to IDLE with i2c_clk remaining 1.
- Nominal period = 2*hp + SYNC_STAGES + 1 cycles.
- en deasserted at any point: the current LOW/RELEASE/HIGH sequence completes. The stop is always SCL high with scl_oe=0.
- timeout_err is sticky.
  - Cleared by err_clr or by reset.
  - If set and clear occur in the same cycle, set wins.
  - While timeout_err=1, the IDLE-to-LOW transition is blocked.
- Strobes are mutually exclusive, since hp/2 >= 2 is guaranteed by MIN_DIV. Each strobe is exactly one cycle wide.
- busy = (state != IDLE).

Decomposition:
- Shared package i2c_pkg:
  - state enum scl_state_t with values IDLE, LOW, RELEASE, HIGH;
  - default constants I2C_CNT_W, I2C_MIN_DIV, I2C_SYNC_STAGES, I2C_TO_W.
- One sub-module, i2c_sync: a parametrised multi-flop bit synchroniser with a reset value input, used for scl_in.

Test Plan:
- Ideal pull-up, SYNC_STAGES=2, half_period=10, en held high -> steady period of 23 cycles: LOW 10, RELEASE 3, HIGH 10. drive_stb at LOW count 5, sample_stb at HIGH count 5, one scl_fall_stb and one scl_rise_stb per period.
- half_period=1 -> clamped to 4: LOW 4 cycles, HIGH 4 cycles, period 11. drive_stb and sample_stb at count 2.
- Target holds scl_in low for 40 extra cycles after release, timeout_limit=0 -> stretching high for 43 cycles, scl_rise_stb delayed accordingly, no timeout_err, then a normal HIGH phase of 10 cycles.
- timeout_limit=20, scl_in held low permanently -> after 20 RELEASE cycles timeout_err=1, state IDLE, scl_oe=0, busy=0. en stays high, but no restart occurs until err_clr is pulsed.
- en dropped at LOW count 3 -> LOW, RELEASE and HIGH all complete, then IDLE with i2c_clk=1. No further scl_fall_stb.
- reset pulsed at HIGH count 6 -> next edge gives all reset values. With en=1 after reset, the first scl_fall_stb appears one cycle after reset deasserts.
